// File: rtl/snake_pkg.sv
// Shared direction codes and helpers for the snake input path.
// Codes 1..4 run clockwise, so opposite headings differ by two.
package snake_pkg;

  localparam int DIR_W = 3;

  localparam logic [DIR_W-1:0] DIR_UP    = 3'd1;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd2;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd3;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd4;

  function automatic logic is_opposite(
    input logic [DIR_W-1:0] a,
    input logic [DIR_W-1:0] b
  );
    logic [DIR_W-1:0] d;
    d = (a > b) ? a - b : b - a;
    return d == 3'd2;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronize, debounce and edge-detect one raw push button.
// press_edge pulses once per debounced press; release is silent.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press_edge
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_edge;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_flip;

  assign w_diff     = r_s2 ^ r_lvl;
  assign w_flip     = w_diff && (r_cnt == LAST);
  assign press_edge = r_edge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_lvl  <= 1'b0;
      r_edge <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= btn;
      r_s2   <= r_s1;
      r_edge <= w_flip & r_s2;
      if (w_flip) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/snake_move_input.sv
// Turns four debounced direction buttons into the committed move word.
// Reversals are refused; heading changes commit only on step_tick.
module snake_move_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RESET_MOVE      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        step_tick,
  output logic [31:0] move,
  output logic        pending_valid,
  output logic        rejected
);

  localparam logic [DIR_W-1:0] RST_MOVE = DIR_W'(RESET_MOVE);

  logic [3:0]       w_edge;
  logic             w_press;
  logic [DIR_W-1:0] w_dir;
  logic             w_commit;
  logic [DIR_W-1:0] w_head;
  logic             w_opp;

  logic [DIR_W-1:0] r_move;
  logic [DIR_W-1:0] r_pend;
  logic             r_pend_valid;
  logic             r_rej;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clock(clock), .reset(reset),
    .btn(btn_up), .press_edge(w_edge[0])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clock(clock), .reset(reset),
    .btn(btn_right), .press_edge(w_edge[1])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clock(clock), .reset(reset),
    .btn(btn_down), .press_edge(w_edge[2])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clock(clock), .reset(reset),
    .btn(btn_left), .press_edge(w_edge[3])
  );

  // Fixed priority: up > right > down > left; losers are dropped silently.
  always_comb begin
    w_press = 1'b1;
    w_dir   = DIR_UP;
    if (w_edge[0])      w_dir = DIR_UP;
    else if (w_edge[1]) w_dir = DIR_RIGHT;
    else if (w_edge[2]) w_dir = DIR_DOWN;
    else if (w_edge[3]) w_dir = DIR_LEFT;
    else                w_press = 1'b0;
  end

  assign w_commit = step_tick & r_pend_valid;
  assign w_head   = w_commit ? r_pend : r_move;
  assign w_opp    = is_opposite(w_dir, w_head);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_move       <= RST_MOVE;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_rej        <= 1'b0;
    end else begin
      r_rej <= w_press & w_opp;
      if (w_commit) begin
        r_move       <= r_pend;
        r_pend_valid <= 1'b0;
      end
      if (w_press && !w_opp) begin
        r_pend       <= w_dir;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign move          = {{(32-DIR_W){1'b0}}, r_move};
  assign pending_valid = r_pend_valid;
  assign rejected      = r_rej;

endmodule

// File: tb/tb_snake_move_input.sv
// Randomized bench for snake_move_input against a history-window model.
// The model works from raw-sample history and heading arithmetic.
module tb_snake_move_input;

  localparam int DC = 4;
  localparam int RM = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic        step_tick = 1'b0;
  logic [31:0] move;
  logic        pending_valid;
  logic        rejected;

  int checks = 0;
  int errors = 0;

  snake_move_input #(
    .DEBOUNCE_CYCLES(DC),
    .RESET_MOVE(RM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_up(btn_up),
    .btn_right(btn_right),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .step_tick(step_tick),
    .move(move),
    .pending_valid(pending_valid),
    .rejected(rejected)
  );

  always #5 clock = ~clock;

  // Reference state: raw sample history per button, debounced level,
  // press event seen by arbitration, heading and pending move.
  bit raw_h[4][$];
  bit m_lvl[4];
  bit m_evt[4];
  int m_move;
  int m_pend;
  bit m_pv;
  bit m_rej;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit opp(input int a, input int b);
    return (a - b == 2) || (b - a == 2);
  endfunction

  task automatic m_reset;
    for (int b = 0; b < 4; b++) begin
      raw_h[b].delete();
      repeat (DC + 2) raw_h[b].push_back(1'b0);
      m_lvl[b] = 1'b0;
      m_evt[b] = 1'b0;
    end
    m_move = RM;
    m_pend = 0;
    m_pv   = 1'b0;
    m_rej  = 1'b0;
  endtask

  task automatic m_step;
    bit raw[4];
    int win;
    int h;
    int n;
    bit all;
    raw[0] = btn_up;
    raw[1] = btn_right;
    raw[2] = btn_down;
    raw[3] = btn_left;
    win = 0;
    for (int i = 3; i >= 0; i--)
      if (m_evt[i]) win = i + 1;
    h = (step_tick && m_pv) ? m_pend : m_move;
    if (step_tick && m_pv) begin
      m_move = m_pend;
      m_pv   = 1'b0;
    end
    m_rej = 1'b0;
    if (win != 0) begin
      if (opp(win, h)) m_rej = 1'b1;
      else begin
        m_pend = win;
        m_pv   = 1'b1;
      end
    end
    // Level flips once the last DC synchronized samples all disagree.
    for (int b = 0; b < 4; b++) begin
      n   = raw_h[b].size();
      all = 1'b1;
      for (int j = n - 1 - DC; j <= n - 2; j++)
        if (raw_h[b][j] == m_lvl[b]) all = 1'b0;
      m_evt[b] = 1'b0;
      if (all) begin
        m_lvl[b] = ~m_lvl[b];
        m_evt[b] = m_lvl[b];
      end
      raw_h[b].push_back(raw[b]);
      if (raw_h[b].size() > DC + 2) void'(raw_h[b].pop_front());
    end
  endtask

  task automatic check_outs;
    chk("move", move, 32'(m_move));
    chk("pending_valid", {31'b0, pending_valid}, {31'b0, m_pv});
    chk("rejected", {31'b0, rejected}, {31'b0, m_rej});
  endtask

  task automatic cyc;
    @(posedge clock);
    if (!reset) m_step();
    @(negedge clock);
    check_outs();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic tick;
    step_tick = 1'b1;
    cyc();
    step_tick = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    m_reset();
    #1;
    check_outs();
    repeat (n) begin
      @(negedge clock);
      check_outs();
    end
    reset = 1'b0;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up = v;
      1: btn_right = v;
      2: btn_down = v;
      default: btn_left = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    run(DC + 4);
    set_btn(b, 1'b0);
    run(DC + 4);
  endtask

  int lat;
  int rej_cnt;

  initial begin
    m_reset();
    @(negedge clock);
    do_reset(2);

    run(10);
    tick();
    run(2);

    btn_up = 1'b1;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!pending_valid && lat < 20);
    chk("up_latency", 32'(lat), 32'd7);
    run(2);
    tick();
    chk("up_committed", move, 32'd1);
    btn_up = 1'b0;
    run(DC + 4);

    btn_down = 1'b1;
    run(3);
    btn_down = 1'b0;
    run(DC + 6);
    chk("glitch_no_pend", {31'b0, pending_valid}, 32'd0);

    press(1);
    tick();
    run(2);
    btn_left = 1'b1;
    rej_cnt = 0;
    repeat (DC + 4) begin
      cyc();
      if (rejected) rej_cnt++;
    end
    chk("left_rej_pulses", 32'(rej_cnt), 32'd1);
    btn_left = 1'b0;
    run(DC + 4);
    tick();
    chk("still_right", move, 32'd2);

    press(0);
    press(3);
    tick();
    chk("up_wins_step", move, 32'd1);
    press(3);
    tick();
    chk("left_after_up", move, 32'd4);

    press(1);
    tick();
    btn_up   = 1'b1;
    btn_left = 1'b1;
    run(DC + 4);
    chk("prio_pend", {31'b0, pending_valid}, 32'd1);
    btn_up   = 1'b0;
    btn_left = 1'b0;
    run(DC + 4);

    btn_right = 1'b1;
    run(3);
    do_reset(2);
    chk("reset_move", move, 32'd2);
    run(DC + 6);
    btn_right = 1'b0;
    run(DC + 4);
    tick();

    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(11) == 0) begin
          case (b)
            0: btn_up = ~btn_up;
            1: btn_right = ~btn_right;
            2: btn_down = ~btn_down;
            default: btn_left = ~btn_left;
          endcase
        end
      step_tick = ($urandom_range(9) == 0);
      if ($urandom_range(599) == 0) begin
        step_tick = 1'b0;
        do_reset($urandom_range(3));
      end else begin
        cyc();
      end
    end
    step_tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_move_input.md
Name: snake_move_input

Overview:
- Input-side counterpart of the processor's display export path. Converts four raw direction buttons into the player move code that the regfile injects into the processor.
- Replaces the constant move value (2) the regfile currently receives.
- Synchronizes and debounces each button, then detects press edges.
- Rejects 180-degree reversals. Commits at most one heading change per game step, so the processor sees a stable move word.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized cycles required before a button's debounced level flips. Minimum 1.
- RESET_MOVE, 2: move code loaded on reset (2 = right).

Ports:
- clock  in  1  system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_up  in  1  raw button, active-high, asynchronous to clock.
- btn_right  in  1  raw button, active-high, asynchronous.
- btn_down  in  1  raw button, active-high, asynchronous.
- btn_left  in  1  raw button, active-high, asynchronous.
- step_tick  in  1  one-cycle pulse marking a game step boundary.
- move  out  32  committed move code, zero-extended. Connects to the regfile move input.
- pending_valid  out  1  a pending move is waiting for the next step_tick.
- rejected  out  1  one-cycle pulse: an accepted press was discarded as a reversal.

Behaviour:

Direction codes:
- 1 = up, 2 = right, 3 = down, 4 = left.
- Two codes are opposite when they differ by exactly 2.
- move[31:3] is always 0.

Reset (asynchronous, any cycle, including mid-debounce):
- move = RESET_MOVE.
- pending register = 0; pending_valid = 0; rejected = 0.
- All synchronizer flops, debounced levels and debounce counters = 0.

Per button, in sub-module button_debounce:
- 2-flop synchronizer on the raw input.
- Counter runs while the synchronized level differs from the debounced level. It clears to 0 whenever they match.
- When the counter reaches DEBOUNCE_CYCLES - 1 while still differing, the debounced level flips and the counter clears.
- press_edge is a one-cycle pulse on a debounced 0->1 transition. Release produces no event.
- Latency: a raw rising edge that stays stable produces press_edge 2 + DEBOUNCE_CYCLES cycles later.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no edge.

Press arbitration:
- Applies to press_edge pulses in the same cycle.
- Priority: up > right > down > left. Lower-priority edges in that cycle are dropped.
- Dropped edges do not pulse rejected.

Acceptance:
- The winning code D is compared with the reference heading H.
- H = move_next: the pending code if step_tick commits in this same cycle, otherwise the current move.
- If D is opposite to H: D is discarded, rejected pulses the next cycle, and pending is unchanged.
- Otherwise: pending <= D and pending_valid <= 1. D overwrites any earlier pending code, so the last legal press in a step wins.

Commit:
- On step_tick with pending_valid = 1: move <= pending, and pending_valid clears.
- A press accepted in the same cycle as step_tick becomes the new pending (pending_valid stays 1). It is evaluated against the value just committed.
- On step_tick with pending_valid = 0: move holds.

Invariants:
- move changes only on cycles following step_tick.
- A committed move is never opposite to the previous committed move.
- A press equal to the current move is legal and becomes pending; committing it leaves move unchanged.

Other boundary cases:
- Buttons held down: no repeat events.
- Button held through reset: after reset it must debounce again and produces a press_edge.

Decomposition:
- Shared package snake_pkg holds:
  - direction constants DIR_UP = 1, DIR_RIGHT = 2, DIR_DOWN = 3, DIR_LEFT = 4;
  - DIR_W = 3;
  - an is_opposite(a, b) function.
- Sub-module button_debounce (synchronizer, counter, debounced level, press_edge), instantiated four times.
- Top level contains the arbitration, acceptance, pending register and commit logic.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Reset release, no stimulus → move = 2, pending_valid = 0, rejected = 0 indefinitely. Pulse step_tick → move stays 2.
2. btn_up high and held → pending_valid rises 7 cycles after the raw edge (2 sync + 4 debounce + 1 register). Next step_tick → move = 1 the following cycle, pending_valid = 0.
3. btn_down toggled high for 3 cycles then low → no pending_valid, no rejected, move unchanged.
4. move = 2, debounced btn_left press → rejected pulses for exactly 1 cycle, pending_valid stays 0. After step_tick, move still 2.
5. move = 2: press up, later press left within the same step, then step_tick → left is rejected (opposite to committed right), move = 1. Next, press left, then step_tick → move = 4.
6. btn_up and btn_left debounced edges in the same cycle, move = 2 → pending = 1 (priority), no rejected. Then assert reset mid-debounce of btn_right → move = 2 immediately, pending_valid = 0, and no later edge unless btn_right re-debounces.
